// File: rtl/cursor_overlay.sv
// Mouse-pointer overlay: draws an arrow cursor over the selected pixel stream.
// The position is latched once per frame, and all outputs have a fixed 2-clk latency.
module cursor_overlay #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned CUR_H      = 16,
    parameter int unsigned CUR_W      = 11,
    parameter logic [11:0] COL_BORDER = 12'h000,
    parameter logic [11:0] COL_MENU   = 12'hFFF,
    parameter logic [11:0] COL_MAPA   = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        Select,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0]        X_MAX = 12'(H_ACTIVE - 1);
    localparam logic [11:0]        Y_MAX = 12'(V_ACTIVE - 1);
    localparam logic signed [12:0] CH    = 13'(CUR_H);
    localparam logic signed [12:0] CW    = 13'(CUR_W);

    logic        vsync_prev_q;
    logic [10:0] x_lat_q, y_lat_q;
    logic        sel_lat_q;
    logic [11:0] x_clamp, y_clamp;
    logic        latch_en;

    assign x_clamp  = (xpos > X_MAX) ? X_MAX : xpos;
    assign y_clamp  = (ypos > Y_MAX) ? Y_MAX : ypos;
    assign latch_en = vsync_in && !vsync_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_prev_q <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            sel_lat_q    <= 1'b0;
        end else begin
            vsync_prev_q <= vsync_in;
            if (latch_en) begin
                x_lat_q   <= x_clamp[10:0];
                y_lat_q   <= y_clamp[10:0];
                sel_lat_q <= Select;
            end
        end
    end

    // Signed offsets so a cursor at column/line 0 never wraps to the far side.
    logic signed [12:0] dx, dy;
    logic               inside_d, edge_d;

    always_comb begin
        dx       = $signed({2'b00, hcount_in}) - $signed({2'b00, x_lat_q});
        dy       = $signed({2'b00, vcount_in}) - $signed({2'b00, y_lat_q});
        inside_d = !dx[12] && !dy[12] && (dy < CH) && (dx <= dy) && (dx < CW);
        edge_d   = inside_d && ((dx == 13'sd0) || (dx == dy) ||
                                (dy == CH - 13'sd1) || (dx == CW - 13'sd1));
    end

    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q;
    logic        inside_q, edge_q;
    logic [11:0] rgb_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
            inside_q <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hblnk_q  <= hblnk_in;
            vblnk_q  <= vblnk_in;
            rgb_q    <= rgb_in;
            inside_q <= inside_d;
            edge_q   <= edge_d;
        end
    end

    always_comb begin
        rgb_d = rgb_q;
        if (hblnk_q || vblnk_q) begin
            rgb_d = 12'h000;
        end else if (edge_q) begin
            rgb_d = COL_BORDER;
        end else if (inside_q) begin
            rgb_d = sel_lat_q ? COL_MAPA : COL_MENU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_q;
            vcount_out <= vcount_q;
            hsync_out  <= hsync_q;
            vsync_out  <= vsync_q;
            hblnk_out  <= hblnk_q;
            vblnk_out  <= vblnk_q;
            rgb_out    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_cursor_overlay.sv
// Bench for cursor_overlay: fixed vectors, hand-written corner sequences and
// randomized traffic checked against a frame-level reference model.
module tb_cursor_overlay;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        Select;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    cursor_overlay dut (
        .clk       (clk),
        .rst       (rst),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hblnk_in  (hblnk_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .xpos      (xpos),
        .ypos      (ypos),
        .Select    (Select),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .hblnk_out (hblnk_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } px_t;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] exp;
        string       name;
    } vec_t;

    int  tests = 0;
    int  fails = 0;
    int  m_x, m_y;
    bit  m_sel, m_vprev;
    px_t m_prev;

    // Arrow: line dy of the cursor covers columns 0..min(dy, 10); outline on its borders.
    function automatic logic [11:0] shade(input int h, input int v, input logic hb,
                                          input logic vb, input logic [11:0] rgb,
                                          input int xl, input int yl, input bit sel);
        int dx = h - xl;
        int dy = v - yl;
        bit in_c, bd;
        if (hb || vb) return 12'h000;
        in_c = dx >= 0 && dy >= 0 && dy < 16 && dx <= dy && dx < 11;
        bd   = in_c && (dx == 0 || dx == dy || dy == 15 || dx == 10);
        if (bd) return 12'h000;
        if (in_c) return sel ? 12'hFF0 : 12'hFFF;
        return rgb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x     = 0;
        m_y     = 0;
        m_sel   = 0;
        m_vprev = 0;
        m_prev  = '0;
    endtask

    // Drive one pixel, clock it, then check outputs against the pixel of the previous clock.
    task automatic cycle(input int h, input int v, input logic hs, input logic vs,
                         input logic hb, input logic vb, input logic [11:0] rgb);
        px_t cur;
        int  ox, oy;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        @(posedge clk);
        ox = m_x;
        oy = m_y;
        if (vs && !m_vprev) begin
            m_x   = (xpos > 12'd1023) ? 1023 : int'(xpos);
            m_y   = (ypos > 12'd767) ? 767 : int'(ypos);
            m_sel = Select;
        end
        m_vprev = vs;
        cur = '{h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb,
                rgb: shade(h, v, hb, vb, rgb, ox, oy, m_sel)};
        #1;
        check("model_rgb", 64'(rgb_out), 64'(m_prev.rgb));
        check("model_timing",
              64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
              64'({m_prev.h, m_prev.v, m_prev.hs, m_prev.vs, m_prev.hb, m_prev.vb}));
        m_prev = cur;
    endtask

    task automatic latch(input logic [11:0] x, input logic [11:0] y, input logic sel);
        xpos   = x;
        ypos   = y;
        Select = sel;
        cycle(0, 770, 0, 0, 1, 1, 12'h0F0);
        cycle(0, 771, 0, 1, 1, 1, 12'h0F0);
        cycle(0, 772, 0, 1, 1, 1, 12'h0F0);
        cycle(0, 773, 0, 0, 1, 1, 12'h0F0);
    endtask

    task automatic px(input int h, input int v, input logic [11:0] exp, input string name);
        cycle(h, v, 0, 0, 0, 0, 12'h0F0);
        cycle(h, v, 0, 0, 0, 0, 12'h0F0);
        check(name, 64'(rgb_out), 64'(exp));
    endtask

    task automatic rand_inputs();
        hcount_in = 11'($urandom);
        vcount_in = 11'($urandom);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblnk_in  = 1'($urandom);
        vblnk_in  = 1'($urandom);
        rgb_in    = 12'($urandom);
        xpos      = 12'($urandom);
        ypos      = 12'($urandom);
        Select    = 1'($urandom);
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            @(posedge clk);
            #1;
            check("reset_outputs",
                  64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                       rgb_out}), 64'(0));
        end
        rst = 1'b1;
    endtask

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{100, 200, 12'h000, "tip"};
        tbl[1] = '{101, 205, 12'hFFF, "fill"};
        tbl[2] = '{105, 205, 12'h000, "diag_edge"};
        tbl[3] = '{106, 205, 12'h0F0, "right_outside"};
        tbl[4] = '{100, 215, 12'h000, "bottom_edge"};
        tbl[5] = '{100, 216, 12'h0F0, "below"};

        rst = 1'b0;
        rand_inputs();
        hold_reset(4);

        // Cursor sits at (0,0) in menu colour before the first latch.
        xpos = 12'd500;
        ypos = 12'd500;
        px(1, 3, 12'hFFF, "pre_latch_fill");
        px(0, 0, 12'h000, "pre_latch_tip");

        latch(12'd100, 12'd200, 1'b0);
        foreach (tbl[i]) px(tbl[i].h, tbl[i].v, tbl[i].exp, tbl[i].name);

        latch(12'd100, 12'd200, 1'b1);
        px(101, 205, 12'hFF0, "map_fill");
        Select = 1'b0;
        px(101, 205, 12'hFF0, "map_held_midframe");
        latch(12'd100, 12'd200, 1'b0);
        px(101, 205, 12'hFFF, "menu_after_vsync");

        px(101, 200, 12'h0F0, "line200_outside");
        xpos = 12'd300;
        px(101, 205, 12'hFFF, "no_tear_old_pos");
        px(301, 205, 12'h0F0, "no_tear_new_absent");
        latch(12'd300, 12'd200, 1'b0);
        px(301, 205, 12'hFFF, "moved_next_frame");
        px(101, 205, 12'h0F0, "old_pos_gone");

        latch(12'd4000, 12'd760, 1'b0);
        px(1023, 760, 12'h000, "clamp_tip");
        px(1022, 761, 12'h0F0, "clip_left");
        px(1020, 761, 12'h0F0, "clip_left_far");
        px(1023, 775, 12'h000, "clip_bottom_edge");
        px(0, 0, 12'h0F0, "no_wrap_origin");
        px(0, 761, 12'h0F0, "no_wrap_col0");

        // Blanking on a cursor pixel must hit exactly 2 clk later, timing aligned.
        latch(12'd100, 12'd200, 1'b0);
        cycle(101, 205, 0, 0, 0, 0, 12'h0F0);
        cycle(101, 205, 1, 0, 1, 0, 12'h0F0);
        cycle(102, 205, 0, 0, 0, 0, 12'h0F0);
        check("blank_rgb", 64'(rgb_out), 64'(12'h000));
        check("blank_hsync", 64'({hsync_out, hblnk_out}), 64'(2'b11));
        cycle(103, 205, 0, 0, 0, 0, 12'h0F0);
        check("after_blank_rgb", 64'(rgb_out), 64'(12'hFFF));
        check("after_blank_hsync", 64'({hsync_out, hblnk_out}), 64'(2'b00));

        // Randomized traffic around the latched cursor, with an asynchronous reset midway.
        for (int n = 0; n < 3000; n++) begin
            int hh, vv;
            if (n == 1500) begin
                #3;
                rst = 1'b0;
                #1;
                check("async_reset_now",
                      64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                           vblnk_out, rgb_out}), 64'(0));
                hold_reset(3);
            end
            hh = m_x + int'($urandom_range(0, 15)) - 2;
            vv = m_y + int'($urandom_range(0, 19)) - 2;
            if (hh < 0) hh = 0;
            if (vv < 0) vv = 0;
            if ($urandom_range(0, 3) == 0) begin
                xpos = 12'($urandom);
                ypos = 12'($urandom);
            end else begin
                xpos = 12'($urandom_range(0, 1100));
                ypos = 12'($urandom_range(0, 800));
            end
            Select = 1'($urandom);
            cycle(hh, vv, 1'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 12'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Display-path stage directly downstream of the menu/map selector.
- Consumes the selected 12-bit pixel stream and the registered mouse position and Select flag from the selector.
- Draws a mouse-pointer arrow over the active picture and forwards the VGA timing signals aligned to the modified pixel stream.
- Position is latched once per frame so the cursor never tears mid-frame.

Parameters:
- H_ACTIVE, 1024, visible pixels per line; latched x is clamped to H_ACTIVE-1.
- V_ACTIVE, 768, visible lines per frame; latched y is clamped to V_ACTIVE-1.
- CUR_H, 16, cursor height in lines.
- CUR_W, 11, cursor maximum width in pixels.
- COL_BORDER, 12'h000, cursor outline colour.
- COL_MENU, 12'hFFF, cursor fill colour when Select=0.
- COL_MAPA, 12'hFF0, cursor fill colour when Select=1.

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, asynchronous active-low reset.
- hcount_in, in, 11, horizontal pixel counter.
- vcount_in, in, 11, vertical line counter.
- hsync_in, in, 1, horizontal sync, active-high.
- vsync_in, in, 1, vertical sync, active-high.
- hblnk_in, in, 1, horizontal blanking.
- vblnk_in, in, 1, vertical blanking.
- rgb_in, in, 12, pixel from the selector.
- xpos, in, 12, cursor x from the selector.
- ypos, in, 12, cursor y from the selector.
- Select, in, 1, 0=menu, 1=map; chooses fill colour.
- hcount_out, vcount_out, out, 11 each, delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out, out, 1 each, delayed timing.
- rgb_out, out, 12, pixel with cursor overlaid.

Behaviour:
- Reset (rst=0, asynchronous): all outputs, pipeline registers and the vsync edge register clear to 0. x_lat, y_lat and sel_lat clear to 0. After rst rises, the cursor is drawn at (0,0) in COL_MENU until the first latch.
- Frame latch: on the first clk where vsync_in=1 and the previous vsync_in=0, capture x_lat=min(xpos,H_ACTIVE-1), y_lat=min(ypos,V_ACTIVE-1) and sel_lat=Select. Latched values are held for the whole next frame. Changes of xpos, ypos or Select at any other time have no effect until the next rising vsync edge.
- Pipeline: fixed latency 2 clk for every output. All timing signals and counters pass through 2 register stages unchanged.
- Stage 1 (registered):
  - dx = hcount_in - x_lat and dy = vcount_in - y_lat, computed as 13-bit signed values; negative means outside.
  - inside = (dx>=0) && (dy>=0) && (dy<CUR_H) && (dx<=dy) && (dx<CUR_W).
  - edge = inside && (dx==0 || dx==dy || dy==CUR_H-1 || dx==CUR_W-1).
  - rgb_in, inside and edge are registered.
- Stage 2 (registered), priority order:
  1. If the delayed hblnk or vblnk is set, rgb_out=12'h000.
  2. Else if edge, rgb_out=COL_BORDER.
  3. Else if inside, rgb_out = sel_lat ? COL_MAPA : COL_MENU.
  4. Else rgb_out = delayed rgb_in.
- Clipping: a cursor near the right or bottom edge is truncated, not wrapped. Pixels with hcount>=H_ACTIVE are blanked anyway. The signed compare prevents wrap at x_lat=0 or y_lat=0.
- Simultaneous rising vsync and position change: the value present on that same clk is the one latched.
- Reset mid-frame: outputs drop to 0 immediately. Output is valid again 2 clk after the first post-reset input cycle.

Test Plan:
- Reset: hold rst=0 with random inputs -> every output is 0. Release rst -> after 2 clk, hcount_out equals hcount_in delayed by 2.
- Basic draw: xpos=100, ypos=200, Select=0, one vsync pulse, then a frame with rgb_in=12'h0F0 ->
  - (100,200)=000
  - (101,205)=FFF
  - (105,205)=000 (diagonal edge)
  - (106,205)=0F0 (outside)
  - (100,215)=000 (bottom edge)
  - (100,216)=0F0
- Map colour: Select=1 latched, same position -> (101,205)=FF0. Changing Select to 0 mid-frame leaves FF0 until the next vsync.
- No tearing: change xpos to 300 while vcount=200 -> the cursor stays at x=100 for the rest of the frame and is at x=300 in the next frame.
- Clamp and clip: xpos=4000, ypos=760 -> x_lat=1023, y_lat=760. Pixel (1023,760) is COL_BORDER. No cursor pixels appear at hcount<1023 on line 761, and no pixels wrap to line 0 or column 0.
- Blanking and latency: set hblnk_in=1 on a pixel inside the cursor -> rgb_out=000 exactly 2 clk later, with hsync/vsync alignment preserved cycle-for-cycle.
